// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port word memory.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is data-first fixed priority.
module mem_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   logic d_win;
   logic d_mis;
   logic pend_valid;
   logic pend_owner;   // 1: data port owns the pending read, 0: fetch
   logic pend_err;
   logic unused_if_low;

   assign unused_if_low = ^if_addr[1:0];
   assign d_mis         = (d_addr[1:0] != 2'b00);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d;   // 1: data was granted most recently

   always_ff @(posedge clk) begin
      if (reset)       last_d <= 1'b0;
      else if (d_gnt)  last_d <= 1'b1;
      else if (if_gnt) last_d <= 1'b0;
   end

   assign d_win = d_req & (~if_req | ~last_d);
`else
   assign d_win = d_req;
`endif

   assign d_gnt  = ~reset & d_win;
   assign if_gnt = ~reset & if_req & ~d_win;

   // Misaligned data grants consume the slot but never reach the memory.
   always_comb begin
      mem_en    = if_gnt | (d_gnt & ~d_mis);
      mem_we    = d_gnt & d_we & ~d_mis;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      if (d_gnt) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (if_gnt) begin
         mem_addr  = {if_addr[31:2], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid <= 1'b0;
         pend_owner <= 1'b0;
         pend_err   <= 1'b0;
      end else begin
         pend_valid <= if_gnt | (d_gnt & ~d_we & ~d_mis);
         pend_owner <= d_gnt;
         pend_err   <= d_gnt & d_mis;
      end
   end

   assign if_rvalid = ~reset & pend_valid & ~pend_owner;
   assign d_rvalid  = ~reset & pend_valid & pend_owner;
   assign d_err     = ~reset & pend_err;
   assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
   assign d_rdata   = d_rvalid  ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_en, mem_we;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

   int total = 0;
   int passed = 0;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
   endtask

   // Environment memory; mem_rdata is garbage whenever no read is returning.
   logic [31:0] mem    [0:1023];
   logic [31:0] shadow [0:1023];

   always @(posedge clk) begin
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[11:2]];
      else                   mem_rdata <= $urandom;
      if (mem_en && mem_we)  mem[mem_addr[11:2]] <= mem_wdata;
   end

   // Reference model: which response is owed next cycle, and who won last.
   typedef enum {R_NONE, R_IF, R_D, R_ERR} resp_e;
   resp_e       m_resp   = R_NONE;
   logic [31:0] m_data   = 32'h0;
   bit          m_last_d = 1'b0;
   bit          e_dw, e_ig, e_dg, e_mis;
   logic [31:0] e_addr;

   always @(negedge clk) begin
      e_mis = (d_addr % 4) != 0;
      if (d_req && if_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         e_dw = !m_last_d;
`else
         e_dw = 1'b1;
`endif
      end else begin
         e_dw = d_req;
      end
      e_dg   = !reset && e_dw;
      e_ig   = !reset && if_req && !e_dw;
      e_addr = e_dg ? d_addr : (e_ig ? (if_addr / 4) * 4 : 32'h0);
      chk1 ("if_gnt",    if_gnt,    e_ig);
      chk1 ("d_gnt",     d_gnt,     e_dg);
      chk1 ("mem_en",    mem_en,    e_ig || (e_dg && !e_mis));
      chk1 ("mem_we",    mem_we,    e_dg && d_we && !e_mis);
      chk32("mem_addr",  mem_addr,  e_addr);
      chk32("mem_wdata", mem_wdata, e_dg ? d_wdata : 32'h0);
      chk1 ("if_rvalid", if_rvalid, !reset && m_resp == R_IF);
      chk32("if_rdata",  if_rdata,  (!reset && m_resp == R_IF) ? m_data : 32'h0);
      chk1 ("d_rvalid",  d_rvalid,  !reset && m_resp == R_D);
      chk32("d_rdata",   d_rdata,   (!reset && m_resp == R_D) ? m_data : 32'h0);
      chk1 ("d_err",     d_err,     !reset && m_resp == R_ERR);
      m_resp = R_NONE;
      if (reset) begin
         m_last_d = 1'b0;
      end else if (e_ig) begin
         m_resp   = R_IF;
         m_data   = shadow[if_addr[11:2]];
         m_last_d = 1'b0;
      end else if (e_dg) begin
         m_last_d = 1'b1;
         if (e_mis)     m_resp = R_ERR;
         else if (d_we) shadow[d_addr[11:2]] = d_wdata;
         else begin
            m_resp = R_D;
            m_data = shadow[d_addr[11:2]];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   bit sg_if, sg_d;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]    = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
         shadow[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
      end
      mem[2]    = 32'h0050_0113;
      shadow[2] = 32'h0050_0113;
      reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
      step(); step();
      smp();
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_d_rvalid", d_rvalid, 1'b0);

      // Single fetch from word 2
      step(); reset = 1'b0; if_req = 1'b1; if_addr = 32'h8;
      smp();
      chk1 ("sf_if_gnt", if_gnt, 1'b1);
      chk32("sf_mem_addr", mem_addr, 32'h8);
      step(); if_req = 1'b0;
      smp();
      chk1 ("sf_if_rvalid", if_rvalid, 1'b1);
      chk32("sf_if_rdata", if_rdata, 32'h0050_0113);

      // Write 25 to 0x64, then read it back
      step(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h64; d_wdata = 32'd25;
      smp();
      chk1 ("wr_d_gnt", d_gnt, 1'b1);
      chk1 ("wr_mem_we", mem_we, 1'b1);
      chk32("wr_mem_wdata", mem_wdata, 32'd25);
      step(); d_we = 1'b0; d_wdata = 32'h0;
      smp();
      chk1("rd_d_gnt", d_gnt, 1'b1);
      chk1("rd_if_rvalid", if_rvalid, 1'b0);
      step(); d_req = 1'b0;
      smp();
      chk1 ("rd_d_rvalid", d_rvalid, 1'b1);
      chk32("rd_d_rdata", d_rdata, 32'd25);
      chk1 ("rd_if_rvalid2", if_rvalid, 1'b0);

      // Contention straight after reset
      step(); reset = 1'b1;
      step(); reset = 1'b0; if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_addr = 32'h64;
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = 0; k < 4; k++) begin
         smp();
         chk1("rr_d_gnt", d_gnt, (k % 2) == 0);
         chk1("rr_if_gnt", if_gnt, (k % 2) == 1);
         if (k > 0) begin
            chk1("rr_d_rvalid", d_rvalid, (k % 2) == 1);
            chk1("rr_if_rvalid", if_rvalid, (k % 2) == 0);
         end
         step();
      end
      if_req = 1'b0; d_req = 1'b0;
      smp();
      chk1 ("rr_last_if_rvalid", if_rvalid, 1'b1);
      chk32("rr_last_if_rdata", if_rdata, 32'h0050_0113);
`else
      for (int k = 0; k < 3; k++) begin
         smp();
         chk1("fp_d_gnt", d_gnt, 1'b1);
         chk1("fp_if_gnt", if_gnt, 1'b0);
         if (k > 0) chk32("fp_d_rdata", d_rdata, 32'd25);
         step();
      end
      d_req = 1'b0;
      smp();
      chk1("fp_if_gnt_after", if_gnt, 1'b1);
      chk1("fp_d_rvalid_after", d_rvalid, 1'b1);
      step(); if_req = 1'b0;
`endif

      // Misaligned data read
      step(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h62;
      smp();
      chk1("mis_d_gnt", d_gnt, 1'b1);
      chk1("mis_mem_en", mem_en, 1'b0);
      step(); d_req = 1'b0;
      smp();
      chk1("mis_d_err", d_err, 1'b1);
      chk1("mis_d_rvalid", d_rvalid, 1'b0);

      // Read presented while reset is high
      step(); reset = 1'b1; d_req = 1'b1; d_addr = 32'h64;
      smp();
      chk1("rma_d_gnt", d_gnt, 1'b0);
      chk1("rma_mem_en", mem_en, 1'b0);
      step(); reset = 1'b0; d_req = 1'b0;
      smp();
      chk1("rma_d_rvalid", d_rvalid, 1'b0);
      chk1("rma_d_err", d_err, 1'b0);

      // Randomized traffic; requests are held until granted
      sg_if = 1'b0; sg_d = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         step();
         reset = ($urandom_range(0, 59) == 0);
         if (!if_req || sg_if) begin
            if_req  = $urandom_range(0, 1);
            if_addr = {20'h0, 6'($urandom_range(0, 63)), 4'($urandom)};
         end
         if (!d_req || sg_d) begin
            d_req   = $urandom_range(0, 1);
            d_we    = $urandom_range(0, 1);
            d_wdata = $urandom;
            d_addr  = {22'h0, 6'($urandom_range(0, 63)), 2'b00, 2'b00};
            d_addr  = {24'h0, d_addr[9:4], 2'b00};
            if ($urandom_range(0, 6) == 0) d_addr[1:0] = 2'($urandom_range(1, 3));
         end
         smp();
         sg_if = if_gnt;
         sg_d  = d_gnt;
      end
      step(); reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
      step(); step();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, reset.
REQ-002 The ports SHALL be, in this order (name, direction, width, meaning):
 - clk  in  1  system clock, rising-edge
 - reset  in  1  synchronous active-high reset
 - if_req  in  1  instruction-fetch read request
 - if_addr  in  32  fetch byte address
 - if_gnt  out  1  fetch request accepted this cycle
 - if_rvalid  out  1  fetch read data valid
 - if_rdata  out  32  fetch read data
 - d_req  in  1  data request
 - d_we  in  1  data write (1) / read (0)
 - d_addr  in  32  data byte address
 - d_wdata  in  32  data write value
 - d_gnt  out  1  data request accepted this cycle
 - d_rvalid  out  1  data read data valid
 - d_rdata  out  32  data read data
 - d_err  out  1  misaligned data access, pulse
 - mem_en  out  1  memory access strobe
 - mem_we  out  1  memory write enable
 - mem_addr  out  32  memory byte address
 - mem_wdata  out  32  memory write data
 - mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0

Function
REQ-003 The block SHALL share one single-port word memory between the fetch and data requesters.
REQ-004 A requester SHALL hold req, addr, we and wdata stable until it sees gnt high.
REQ-005 The gnt outputs SHALL be combinational from the requests and the arbitration state; at most one gnt SHALL be high per cycle.
REQ-006 If exactly one requester asserts req, that requester SHALL be granted in the same cycle.
REQ-007 On a grant, mem_en=1, and mem_addr and mem_we SHALL be driven from the granted port in the same cycle; mem_we SHALL be 0 for fetch.
REQ-008 On a data grant, mem_wdata SHALL equal d_wdata; otherwise mem_wdata SHALL be 0.
REQ-009 A granted read SHALL produce exactly one rvalid pulse on the owning port one cycle later, with rdata=mem_rdata.
REQ-010 A granted write SHALL produce no rvalid.
REQ-011 A new grant SHALL be allowed in the same cycle as a pending rvalid, giving a throughput of one access per cycle.
REQ-012 A pending-response register (owner, valid) SHALL route mem_rdata to the correct port.
REQ-013 When rvalid is low, rdata SHALL be 0.
REQ-014 A data request with d_addr[1:0]!=0 SHALL:
 - be granted as normal (d_gnt=1), but with mem_en=0;
 - produce d_err=1 one cycle later, with no d_rvalid;
 - still take part in arbitration.
REQ-015 Fetch addresses SHALL be treated as word-aligned; if_addr[1:0] SHALL be ignored and mem_addr[1:0] forced to 0.
REQ-016 When neither requester asserts req, mem_en, mem_we and both gnt outputs SHALL be 0.

Reset
REQ-017 When reset is sampled high, on that clock edge:
 - the pending response SHALL be cleared, and no rvalid or d_err SHALL follow a request granted in the same cycle as reset;
 - the arbitration pointer SHALL be set to "fetch last granted".
REQ-018 While reset is high, all gnt, rvalid, d_err and mem_* outputs SHALL be 0 and no access SHALL be issued.
REQ-019 After reset deasserts, the first contested cycle SHALL grant data.

Configuration
REQ-020 With ARB_ROUND_ROBIN_EN defined:
 - when both requesters assert req, the port not granted most recently SHALL be granted;
 - the last-granted pointer SHALL update on every grant, including misaligned data grants.
REQ-021 Without ARB_ROUND_ROBIN_EN, data SHALL always win a contested cycle (fixed priority), and the pointer SHALL be absent.

Verification
REQ-022 Single fetch: if_req=1, if_addr=0x8 with mem word[2]=0x00500113 → if_gnt=1 in the same cycle, mem_addr=0x8, then if_rvalid=1 with if_rdata=0x00500113 one cycle later.
REQ-023 Write then read: data write to 0x64 with value 25 is granted, then a read of 0x64 → d_rvalid=1, d_rdata=25, if_rvalid=0 throughout.
REQ-024 Contention with ARB_ROUND_ROBIN_EN: both req held for 4 cycles after reset → grants D, IF, D, IF, and each read response lands on the correct port back-to-back.
REQ-025 Contention without the macro: both req held for 3 cycles → d_gnt=1 every cycle and if_gnt=0 until d_req drops.
REQ-026 Misaligned access: d_req=1, d_we=0, d_addr=0x62 → d_gnt=1, mem_en=0, then d_err=1 and d_rvalid=0 next cycle.
REQ-027 Reset mid-access: a read is granted in the same cycle reset=1 → no rvalid on the following cycle, and all outputs are 0.
